fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: drives ROM address, buffers words in a prefetch FIFO,
// hands {inst, pc} downstream, and flushes/restarts on redirect.
module fetch_unit #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  output logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [SIZE-1:0]       idata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE-1:0]       out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic [SIZE-1:0]       inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  unused_pc_low;

  assign unused_pc_low = ^redirect_pc[1:0];

  // The in-flight request reserves a slot, so a push can never hit a full FIFO.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, req_q};
  assign issue     = redirect_valid || (occupancy < DEPTH_V);
  assign issue_pc  = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00} : fetch_pc;
  assign iaddr     = {2'b00, issue_pc[ADDR_WIDTH-1:2]};

  assign push      = req_q && !redirect_valid;
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc <= '0;
      req_q    <= 1'b0;
      req_pc_q <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= issue_pc + ADDR_WIDTH'(4);
        req_q    <= 1'b1;
        req_pc_q <= issue_pc;
      end else begin
        req_q    <= 1'b0;
      end

      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      inst_mem[wr_ptr] <= idata;
      pc_mem[wr_ptr]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a synchronous ROM model
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  iaddr;
  logic [31:0] idata = '0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [9:0]  out_pc;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          max_cnt = 0;
  logic [9:0]  exp_q [$];
  logic [9:0]  e_pc;

  fetch_unit #(.SIZE(32), .ADDR_WIDTH(10), .DEPTH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 CLK = ~CLK;

  // ROM word k holds 0x1000_0000 + k, one cycle read latency.
  always @(posedge CLK) idata <= 32'h1000_0000 + 32'(iaddr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e_pc = exp_q.pop_front();
        chk("sb_out_pc", {54'd0, out_pc}, {54'd0, e_pc});
        chk("sb_out_inst", {32'd0, out_inst}, {32'd0, 32'h1000_0000 + 32'(e_pc >> 2)});
      end
    end
  end

  task automatic push_seq(input logic [9:0] start, input int n);
    logic [9:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 10'd4;
    end
  endtask

  task automatic restart(input logic ready, input int n);
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    redirect_valid = 1'b0;
    out_ready = ready;
    exp_q.delete();
    push_seq(10'd0, n);
    max_cnt = 0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
  endtask

  task automatic redirect_cycle(input logic [9:0] target, input logic [9:0] first, input int n);
    @(posedge CLK); #1;
    redirect_valid = 1'b1;
    redirect_pc = target;
    exp_q.delete();
    push_seq(first, n);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_iaddr", {54'd0, iaddr}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_pc", {54'd0, out_pc}, 64'd0);

    // Startup latency and sustained throughput
    push_seq(10'd0, 20);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK); chk("t1_c0_valid", {63'd0, out_valid}, 64'd0);
    @(negedge CLK); chk("t1_c1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge CLK); chk("t1_c2_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_c2_pc", {54'd0, out_pc}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); chk("t1_stream_valid", {63'd0, out_valid}, 64'd1);
    end
    wait_drain("t1_drain");

    // Backpressure
    restart(1'b0, 16);
    repeat (10) @(negedge CLK);
    chk("t2_stall_iaddr", {54'd0, iaddr}, 64'd4);
    chk("t2_stall_head", {54'd0, out_pc}, 64'd0);
    chk("t2_max_count", 64'(max_cnt), 64'd4);
    @(negedge CLK);
    chk("t2_stall_iaddr2", {54'd0, iaddr}, 64'd4);
    chk("t2_stall_valid", {63'd0, out_valid}, 64'd1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); chk("t2_release_valid", {63'd0, out_valid}, 64'd1);
    end
    wait_drain("t2_drain");
    chk("t2_count_bound", 64'(max_cnt), 64'd4);

    // Redirect with 3 entries buffered and one request in flight
    restart(1'b0, 0);
    repeat (3) @(posedge CLK);
    redirect_cycle(10'h100, 10'h100, 4);
    out_ready = 1'b1;
    @(negedge CLK);
    chk("t3_redir_valid", {63'd0, out_valid}, 64'd0);
    chk("t3_redir_iaddr", {54'd0, iaddr}, 64'h40);
    @(posedge CLK); #1; redirect_valid = 1'b0;
    @(negedge CLK); chk("t3_t1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge CLK); chk("t3_t2_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_t2_pc", {54'd0, out_pc}, 64'h100);
    wait_drain("t3_drain");

    // Back-to-back redirects: only the second target is delivered
    redirect_cycle(10'h080, 10'h000, 0);
    redirect_cycle(10'h200, 10'h200, 3);
    @(posedge CLK); #1; redirect_valid = 1'b0;
    @(negedge CLK); chk("t4_t2_valid", {63'd0, out_valid}, 64'd0);
    @(negedge CLK); chk("t4_t3_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_t3_pc", {54'd0, out_pc}, 64'h200);
    wait_drain("t4_drain");

    // Misaligned target
    redirect_cycle(10'h0FE, 10'h0FC, 3);
    @(posedge CLK); #1; redirect_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK); chk("t5_pc", {54'd0, out_pc}, 64'h0FC);
    wait_drain("t5_drain");

    // PC wrap-around
    redirect_cycle(10'h3F8, 10'h3F8, 4);
    @(posedge CLK); #1; redirect_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK); chk("t6_pc", {54'd0, out_pc}, 64'h3F8);
    wait_drain("t6_drain");

    // Asynchronous reset with a full FIFO
    redirect_cycle(10'h040, 10'h000, 0);
    out_ready = 1'b0;
    @(posedge CLK); #1; redirect_valid = 1'b0;
    repeat (8) @(negedge CLK);
    chk("t7_full_valid", {63'd0, out_valid}, 64'd1);
    @(posedge CLK); #3;
    RESET_N = 1'b0;
    #1;
    chk("t7_async_valid", {63'd0, out_valid}, 64'd0);
    chk("t7_async_pc", {54'd0, out_pc}, 64'd0);
    chk("t7_async_inst", {32'd0, out_inst}, 64'd0);
    chk("t7_async_iaddr", {54'd0, iaddr}, 64'd0);
    exp_q.delete();
    push_seq(10'd0, 6);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK); chk("t7_c1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge CLK); chk("t7_c2_pc", {54'd0, out_pc}, 64'd0);
    chk("t7_c2_valid", {63'd0, out_valid}, 64'd1);
    wait_drain("t7_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
